// File: rtl/secp256k1_mult_iter_if.sv
// Operand/result handshake bundle for the iterative 256x256 multiplier.
// The master drives operands and downstream ready; the slave is the multiplier.
interface secp256k1_mult_iter_if #(
    parameter int unsigned CTL_BITS = 8
);
    logic [255:0]          i_dat_a;
    logic [255:0]          i_dat_b;
    logic                  i_val;
    logic                  i_err;
    logic [CTL_BITS-1:0]   i_ctl;
    logic                  o_rdy;
    logic [511:0]          o_dat;
    logic                  o_val;
    logic                  i_rdy;
    logic [CTL_BITS-1:0]   o_ctl;
    logic                  o_err;

    modport master (
        output i_dat_a, i_dat_b, i_val, i_err, i_ctl, i_rdy,
        input  o_rdy, o_dat, o_val, o_ctl, o_err
    );

    modport slave (
        input  i_dat_a, i_dat_b, i_val, i_err, i_ctl, i_rdy,
        output o_rdy, o_dat, o_val, o_ctl, o_err
    );
endinterface

// File: rtl/secp256k1_mult_iter.sv
// Iterative 256x256 -> 512 multiplier: one DIGIT_BITS-wide multiplier digit per cycle,
// exact 512-bit accumulation, with secp256k1 range check folded into the error flag.
module secp256k1_mult_iter #(
    parameter int unsigned CTL_BITS   = 8,
    parameter int unsigned DIGIT_BITS = 64
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    secp256k1_mult_iter_if.slave          bus
);
    localparam int unsigned N     = 256 / DIGIT_BITS;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW    = 256 + DIGIT_BITS;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MULT = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    localparam logic [255:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [255:0]          a;
    logic [255:0]          b;
    logic [511:0]          acc;
    logic                  err;
    logic [CTL_BITS-1:0]   ctl;

    logic [8:0]            shamt;
    logic [DIGIT_BITS-1:0] digit;
    logic [PW-1:0]         partial;
    logic [511:0]          acc_next;

    // One full-width product per cycle so the tool can map it onto DSP blocks.
    always_comb begin
        shamt    = 9'(cnt) * 9'(DIGIT_BITS);
        digit    = DIGIT_BITS'(b >> shamt);
        partial  = PW'(a) * PW'(digit);
        acc_next = acc + (512'(partial) << shamt);
    end

    // Depends only on state and reset, never on downstream ready.
    assign bus.o_rdy = (state == IDLE) && i_rst_n;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            a         <= '0;
            b         <= '0;
            acc       <= '0;
            err       <= 1'b0;
            ctl       <= '0;
            bus.o_val <= 1'b0;
            bus.o_dat <= '0;
            bus.o_ctl <= '0;
            bus.o_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_val) begin
                        a     <= bus.i_dat_a;
                        b     <= bus.i_dat_b;
                        ctl   <= bus.i_ctl;
                        err   <= bus.i_err || (bus.i_dat_a >= P) || (bus.i_dat_b >= P);
                        acc   <= '0;
                        cnt   <= '0;
                        state <= MULT;
                    end
                end
                MULT: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(N - 1)) begin
                        state     <= OUT;
                        bus.o_val <= 1'b1;
                        bus.o_dat <= acc_next;
                        bus.o_ctl <= ctl;
                        bus.o_err <= err;
                    end
                end
                OUT: begin
                    if (bus.i_rdy) begin
                        bus.o_val <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_secp256k1_mult_iter.sv
// Self-checking bench: directed vector table, handshake/reset corner sequences, and
// back-to-back random streams at three digit widths checked against a bignum model.
module tb_secp256k1_mult_iter;
    localparam logic [255:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] ALL1 = {256{1'b1}};
    localparam int NM = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   done_cnt;
    logic start_b2b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    secp256k1_mult_iter_if #(.CTL_BITS(8)) mif ();
    secp256k1_mult_iter #(.CTL_BITS(8), .DIGIT_BITS(64)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (mif.slave)
    );

    function automatic logic [511:0] ref_mul(input logic [255:0] x, input logic [255:0] y);
        return 512'(x) * 512'(y);
    endfunction

    function automatic logic ref_err(input logic e, input logic [255:0] x,
                                     input logic [255:0] y);
        return e || (x >= P) || (y >= P);
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents one operation; returns at #1 after its acceptance edge.
    task automatic issue(input logic [255:0] x, input logic [255:0] y, input logic e,
                         input logic [7:0] c, input logic rdy);
        mif.i_dat_a = x;
        mif.i_dat_b = y;
        mif.i_err   = e;
        mif.i_ctl   = c;
        mif.i_rdy   = rdy;
        mif.i_val   = 1'b1;
        @(posedge clk); #1;
        mif.i_val   = 1'b0;
    endtask

    task automatic wait_val(output int lat);
        lat = 0;
        while (!mif.o_val && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [255:0] a;
        logic [255:0] b;
        logic         e;
        logic [7:0]   c;
        logic [511:0] exp_dat;
        logic         exp_err;
    } vec_t;

    initial begin : main
        vec_t         vt [7];
        int           lat;
        int           extra;
        logic [255:0] ra, rb;
        logic         re;
        logic [7:0]   rc;
        logic [511:0] snap;

        n_tests = 0; n_fail = 0; done_cnt = 0; start_b2b = 1'b0;
        rst_n = 1'b0;
        mif.i_dat_a = '0; mif.i_dat_b = '0; mif.i_val = 1'b0; mif.i_err = 1'b0;
        mif.i_ctl = '0; mif.i_rdy = 1'b1;

        vt[0] = '{a: 256'd3,  b: 256'd5,  e: 1'b0, c: 8'h5A, exp_dat: 512'd15,        exp_err: 1'b0};
        vt[1] = '{a: P - 1,   b: P - 1,   e: 1'b0, c: 8'h11, exp_dat: ref_mul(P - 1, P - 1),
                  exp_err: 1'b0};
        vt[2] = '{a: P,       b: 256'd2,  e: 1'b0, c: 8'h22, exp_dat: 512'(P) << 1,  exp_err: 1'b1};
        vt[3] = '{a: 256'd1,  b: ALL1,    e: 1'b1, c: 8'h33, exp_dat: 512'(ALL1),    exp_err: 1'b1};
        vt[4] = '{a: 256'd0,  b: ALL1,    e: 1'b0, c: 8'h44, exp_dat: 512'd0,        exp_err: 1'b1};
        vt[5] = '{a: P - 1,   b: 256'd1,  e: 1'b0, c: 8'h55, exp_dat: 512'(P - 1),   exp_err: 1'b0};
        vt[6] = '{a: ALL1,    b: ALL1,    e: 1'b0, c: 8'h66, exp_dat: ref_mul(ALL1, ALL1),
                  exp_err: 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 512'(mif.o_rdy), 512'd0);
        chk("rst_val", 512'(mif.o_val), 512'd0);
        chk("rst_dat", mif.o_dat, 512'd0);
        chk("rst_ctl", 512'(mif.o_ctl), 512'd0);
        chk("rst_err", 512'(mif.o_err), 512'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy", 512'(mif.o_rdy), 512'd1);

        for (int i = 0; i < 7; i++) begin
            chk($sformatf("v%0d_rdy_pre", i), 512'(mif.o_rdy), 512'd1);
            issue(vt[i].a, vt[i].b, vt[i].e, vt[i].c, 1'b1);
            wait_val(lat);
            chk($sformatf("v%0d_lat", i), 512'(lat), 512'(NM));
            chk($sformatf("v%0d_dat", i), mif.o_dat, vt[i].exp_dat);
            chk($sformatf("v%0d_ctl", i), 512'(mif.o_ctl), 512'(vt[i].c));
            chk($sformatf("v%0d_err", i), 512'(mif.o_err), 512'(vt[i].exp_err));
            if (i == 1) chk("v1_modred", mif.o_dat % 512'(P), 512'd1);
            @(posedge clk); #1;
            chk($sformatf("v%0d_val_clr", i), 512'(mif.o_val), 512'd0);
            chk($sformatf("v%0d_rdy_post", i), 512'(mif.o_rdy), 512'd1);
        end

        for (int i = 0; i < 8; i++) begin
            ra = rnd256(); rb = rnd256();
            if (i == 3) ra = P + 256'(i);
            re = 1'($urandom_range(0, 1)); rc = 8'($urandom);
            issue(ra, rb, re, rc, 1'b1);
            wait_val(lat);
            chk($sformatf("r%0d_lat", i), 512'(lat), 512'(NM));
            chk($sformatf("r%0d_dat", i), mif.o_dat, ref_mul(ra, rb));
            chk($sformatf("r%0d_ctl", i), 512'(mif.o_ctl), 512'(rc));
            chk($sformatf("r%0d_err", i), 512'(mif.o_err), 512'(ref_err(re, ra, rb)));
            @(posedge clk); #1;
        end

        // Downstream stall: result must hold and new requests must be ignored.
        ra = rnd256(); rb = rnd256();
        issue(ra, rb, 1'b0, 8'hA5, 1'b0);
        wait_val(lat);
        chk("stall_lat", 512'(lat), 512'(NM));
        snap = ref_mul(ra, rb);
        for (int k = 0; k < 10; k++) begin
            mif.i_val   = k[0];
            mif.i_dat_a = rnd256();
            mif.i_err   = 1'b1;
            chk($sformatf("stall%0d_rdy", k), 512'(mif.o_rdy), 512'd0);
            @(posedge clk); #1;
            chk($sformatf("stall%0d_val", k), 512'(mif.o_val), 512'd1);
            chk($sformatf("stall%0d_dat", k), mif.o_dat, snap);
            chk($sformatf("stall%0d_ctl", k), 512'(mif.o_ctl), 512'h A5);
            chk($sformatf("stall%0d_err", k), 512'(mif.o_err), 512'd0);
        end
        mif.i_val = 1'b0; mif.i_err = 1'b0; mif.i_rdy = 1'b1;
        @(posedge clk); #1;
        chk("stall_xfer_val", 512'(mif.o_val), 512'd0);
        chk("stall_xfer_rdy", 512'(mif.o_rdy), 512'd1);
        extra = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (mif.o_val) extra++;
        end
        chk("stall_no_extra", 512'(extra), 512'd0);

        // Reset in the middle of MULT aborts the operation.
        issue(rnd256(), rnd256(), 1'b0, 8'h77, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_rdy_low", 512'(mif.o_rdy), 512'd0);
        chk("abort_val", 512'(mif.o_val), 512'd0);
        chk("abort_dat", mif.o_dat, 512'd0);
        chk("abort_ctl", 512'(mif.o_ctl), 512'd0);
        rst_n = 1'b1;
        #1;
        chk("abort_rdy_rel", 512'(mif.o_rdy), 512'd1);
        issue(256'd7, 256'd9, 1'b0, 8'h79, 1'b1);
        wait_val(lat);
        chk("abort_next_lat", 512'(lat), 512'(NM));
        chk("abort_next_dat", mif.o_dat, 512'd63);
        chk("abort_next_ctl", 512'(mif.o_ctl), 512'h79);
        @(posedge clk); #1;

        start_b2b = 1'b1;
        for (int t = 0; t < 3000 && done_cnt < 3; t++) @(posedge clk);
        #1;
        chk("b2b_done", 512'(done_cnt), 512'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    for (genvar g = 0; g < 3; g++) begin : g_b2b
        localparam int unsigned DB = (g == 0) ? 32 : (g == 1) ? 64 : 256;
        localparam int SP = 256 / DB + 2;

        secp256k1_mult_iter_if #(.CTL_BITS(8)) bif ();
        secp256k1_mult_iter #(.CTL_BITS(8), .DIGIT_BITS(DB)) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .bus     (bif.slave)
        );

        initial begin : drv
            logic [255:0] ra [16];
            logic [255:0] rb [16];
            int   sent, got, cyc, last;
            logic rdy_pre;

            bif.i_val = 1'b0; bif.i_rdy = 1'b1; bif.i_err = 1'b0;
            bif.i_ctl = '0; bif.i_dat_a = '0; bif.i_dat_b = '0;
            wait (start_b2b);
            for (int i = 0; i < 16; i++) begin
                ra[i] = rnd256();
                rb[i] = rnd256();
            end
            sent = 0; got = 0; cyc = 0; last = 0;
            bif.i_dat_a = ra[0]; bif.i_dat_b = rb[0]; bif.i_ctl = 8'd1; bif.i_val = 1'b1;
            while (got < 16 && cyc < 600) begin
                rdy_pre = bif.o_rdy;
                @(posedge clk); #1;
                cyc++;
                if (rdy_pre && bif.i_val) begin
                    sent++;
                    if (sent < 16) begin
                        bif.i_dat_a = ra[sent];
                        bif.i_dat_b = rb[sent];
                        bif.i_ctl   = 8'(sent + 1);
                    end else begin
                        bif.i_val = 1'b0;
                    end
                end
                if (bif.o_val) begin
                    chk($sformatf("b2b%0d_dat%0d", DB, got), bif.o_dat, ref_mul(ra[got], rb[got]));
                    chk($sformatf("b2b%0d_ctl%0d", DB, got), 512'(bif.o_ctl), 512'(got + 1));
                    chk($sformatf("b2b%0d_err%0d", DB, got), 512'(bif.o_err),
                        512'(ref_err(1'b0, ra[got], rb[got])));
                    if (got > 0)
                        chk($sformatf("b2b%0d_gap%0d", DB, got), 512'(cyc - last), 512'(SP));
                    last = cyc;
                    got++;
                end
            end
            chk($sformatf("b2b%0d_count", DB), 512'(got), 512'd16);
            done_cnt++;
        end
    end
endmodule
